// File: rtl/program_counter.sv
// Registered program counter with an optional hardware return-address stack.
// The stack is compiled in only when the macro PC_RETURN_STACK_EN is defined.
// Without it, call behaves as a plain jump, ret is ignored, and all stack and
// flag outputs are tied to their idle values.
//
// Per-edge priority: reset, call&&ret, ret, call, load, inc, hold.
// Every output is a register or a direct decode of one.
module program_counter #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in,
   input  logic                       load,
   input  logic                       inc,
   input  logic                       call,
   input  logic                       ret,
   output logic [WIDTH-1:0]           out,
   output logic [$clog2(DEPTH+1)-1:0] stack_depth,
   output logic                       stack_empty,
   output logic                       stack_full,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       conflict
);

   localparam int DW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;

   // Program counter register; reset wins over every other control.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

`ifdef PC_RETURN_STACK_EN

   localparam int            PW        = $clog2(DEPTH);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

   // Circular storage; top_q points at the most recently pushed entry.
   // A push while full simply advances onto the oldest slot, which is how
   // the oldest return address gets discarded.
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [PW-1:0]    top_q;
   logic [PW-1:0]    top_d;
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    depth_d;
   logic             overflow_q;
   logic             overflow_d;
   logic             underflow_q;
   logic             underflow_d;
   logic             conflict_q;
   logic             conflict_d;
   logic             push_en;
   logic [WIDTH-1:0] ret_addr;

   // Return address is the pre-update PC plus one, wrapping at 2^WIDTH.
   assign ret_addr = out_q + WIDTH'(1);

   // Next-state decode following the per-edge priority order.
   always_comb begin
      out_d       = out_q;
      top_d       = top_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      conflict_d  = conflict_q;
      push_en     = 1'b0;
      if (call && ret) begin
         // Ambiguous request: hold everything and record it.
         conflict_d = 1'b1;
      end else if (ret) begin
         if (depth_q != '0) begin
            out_d   = stack_q[top_q];
            top_d   = top_q - PW'(1);
            depth_d = depth_q - DW'(1);
         end else begin
            underflow_d = 1'b1;
         end
      end else if (call) begin
         out_d   = in;
         push_en = 1'b1;
         top_d   = top_q + PW'(1);
         if (depth_q == DEPTH_MAX) begin
            overflow_d = 1'b1;
         end else begin
            depth_d = depth_q + DW'(1);
         end
      end else if (load) begin
         out_d = in;
      end else if (inc) begin
         out_d = out_q + WIDTH'(1);
      end
   end

   // Stack bookkeeping and sticky flags; flags only clear on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         top_q       <= '0;
         depth_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         conflict_q  <= 1'b0;
      end else begin
         top_q       <= top_d;
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         conflict_q  <= conflict_d;
      end
   end

   // Stack storage write; contents are not reset since depth marks validity.
   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         stack_q[top_d] <= ret_addr;
      end
   end

   assign stack_depth = depth_q;
   assign stack_empty = (depth_q == '0);
   assign stack_full  = (depth_q == DEPTH_MAX);
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;
   assign conflict    = conflict_q;

`else

   // ret has no meaning without a stack.
   logic unused_ret;
   assign unused_ret = ret;

   // Next-state decode: call is an ordinary jump, ret falls through.
   always_comb begin
      out_d = out_q;
      if (call || load) begin
         out_d = in;
      end else if (inc) begin
         out_d = out_q + WIDTH'(1);
      end
   end

   assign stack_depth = DW'(0);
   assign stack_empty = 1'b1;
   assign stack_full  = 1'b0;
   assign overflow    = 1'b0;
   assign underflow   = 1'b0;
   assign conflict    = 1'b0;

`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter (WIDTH=16, DEPTH=4). Builds with or
// without PC_RETURN_STACK_EN; the reference model follows the same macro.
module tb_program_counter;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             clk;
   logic             reset;
   logic [WIDTH-1:0] in;
   logic             load;
   logic             inc;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] out;
   logic [2:0]       stack_depth;
   logic             stack_empty;
   logic             stack_full;
   logic             overflow;
   logic             underflow;
   logic             conflict;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state: the stack is a plain queue, newest at the back.
   logic [WIDTH-1:0] m_pc;
   logic [WIDTH-1:0] m_stk[$];
   logic             m_ovf;
   logic             m_udf;
   logic             m_cnf;
   logic [WIDTH-1:0] exp_q[$];

   program_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in(in), .load(load), .inc(inc),
      .call(call), .ret(ret), .out(out), .stack_depth(stack_depth),
      .stack_empty(stack_empty), .stack_full(stack_full),
      .overflow(overflow), .underflow(underflow), .conflict(conflict)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] m_status();
      logic [2:0] d;
      d = 3'(m_stk.size());
      return {d, (m_stk.size() == 0), (m_stk.size() == DEPTH), m_ovf, m_udf, m_cnf};
   endfunction

   function automatic logic [7:0] dut_status();
      return {stack_depth, stack_empty, stack_full, overflow, underflow, conflict};
   endfunction

   // Model one clock edge from the rules of operation.
   task automatic model_step(input logic r, input logic [WIDTH-1:0] a,
                             input logic l, input logic i, input logic c, input logic t);
      if (r) begin
         m_pc = '0; m_stk.delete(); m_ovf = 0; m_udf = 0; m_cnf = 0;
      end
`ifdef PC_RETURN_STACK_EN
      else if (c && t) m_cnf = 1;
      else if (t) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else m_udf = 1;
      end else if (c) begin
         m_stk.push_back(m_pc + 16'd1);
         if (m_stk.size() > DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1;
         end
         m_pc = a;
      end
`else
      else if (c) m_pc = a;
`endif
      else if (l) m_pc = a;
      else if (i) m_pc = m_pc + 16'd1;
   endtask

   // Driver: apply inputs away from the edge, clock once, advance the model.
   task automatic drive(input logic r, input logic [WIDTH-1:0] a,
                        input logic l, input logic i, input logic c, input logic t);
      @(negedge clk);
      reset = r; in = a; load = l; inc = i; call = c; ret = t;
      @(posedge clk);
      #1;
      model_step(r, a, l, i, c, t);
   endtask

   task automatic test_reset();
      drive(1, 16'h5555, 1, 1, 1, 1);
      n_total++; if (out !== 16'h0000) $display("FAIL reset_out: got %h want 0000", out); else n_pass++;
      n_total++; if (dut_status() !== 8'b000_1_0_000) $display("FAIL reset_status: got %b want 00010000", dut_status()); else n_pass++;
   endtask

   task automatic test_inc_wrap();
      logic [WIDTH-1:0] want[4];
      want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000; want[3] = 16'h0001;
      drive(0, 16'hFFFE, 1, 0, 0, 0);
      n_total++; if (out !== want[0]) $display("FAIL wrap_load: got %h want %h", out, want[0]); else n_pass++;
      for (int k = 1; k < 4; k++) begin
         drive(0, 16'h0000, 0, 1, 0, 0);
         n_total++; if (out !== want[k]) $display("FAIL wrap_inc%0d: got %h want %h", k, out, want[k]); else n_pass++;
      end
      drive(1, 16'h0000, 0, 0, 0, 0);
      n_total++; if (out !== 16'h0000) $display("FAIL wrap_reset: got %h want 0000", out); else n_pass++;
   endtask

   task automatic test_priority();
      drive(0, 16'h1234, 1, 1, 0, 0);
      n_total++; if (out !== 16'h1234) $display("FAIL prio_load_inc: got %h want 1234", out); else n_pass++;
      drive(0, 16'h0000, 0, 0, 0, 0);
      n_total++; if (out !== 16'h1234) $display("FAIL prio_hold: got %h want 1234", out); else n_pass++;
      drive(1, 16'h1234, 1, 1, 0, 0);
      n_total++; if (out !== 16'h0000) $display("FAIL prio_reset: got %h want 0000", out); else n_pass++;
   endtask

`ifdef PC_RETURN_STACK_EN
   task automatic test_nested_call();
      logic [WIDTH-1:0] tgt[4];
      logic [WIDTH-1:0] want[4];
      logic [2:0]       dep[4];
      tgt[0] = 16'h0100; tgt[1] = 16'h0200; tgt[2] = 16'h0; tgt[3] = 16'h0;
      want[0] = 16'h0100; want[1] = 16'h0200; want[2] = 16'h0101; want[3] = 16'h0011;
      dep[0] = 3'd1; dep[1] = 3'd2; dep[2] = 3'd1; dep[3] = 3'd0;
      drive(1, 16'h0, 0, 0, 0, 0);
      drive(0, 16'h0010, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         if (k < 2) drive(0, tgt[k], 1, 1, 1, 0);
         else       drive(0, 16'hBEEF, 1, 1, 0, 1);
         n_total++; if (out !== want[k]) $display("FAIL nested_out%0d: got %h want %h", k, out, want[k]); else n_pass++;
         n_total++; if (stack_depth !== dep[k]) $display("FAIL nested_depth%0d: got %0d want %0d", k, stack_depth, dep[k]); else n_pass++;
      end
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] want[4];
      want[0] = 16'h0041; want[1] = 16'h0031; want[2] = 16'h0021; want[3] = 16'h0011;
      drive(1, 16'h0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) drive(0, 16'(k * 16), 0, 0, 1, 0);
      n_total++; if (out !== 16'h0050) $display("FAIL ovf_out: got %h want 0050", out); else n_pass++;
      n_total++; if ({stack_full, overflow, stack_depth} !== 5'b1_1_100) $display("FAIL ovf_flags: full=%b ovf=%b depth=%0d want 1 1 4", stack_full, overflow, stack_depth); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         drive(0, 16'h0, 0, 0, 0, 1);
         n_total++; if (out !== want[k]) $display("FAIL ovf_ret%0d: got %h want %h", k, out, want[k]); else n_pass++;
      end
      n_total++; if ({stack_empty, overflow, underflow} !== 3'b110) $display("FAIL ovf_drain: empty=%b ovf=%b udf=%b want 1 1 0", stack_empty, overflow, underflow); else n_pass++;
   endtask

   task automatic test_underflow_conflict();
      drive(1, 16'h0, 0, 0, 0, 0);
      drive(0, 16'h0777, 1, 0, 0, 0);
      drive(0, 16'h0000, 0, 1, 0, 1);
      n_total++; if (out !== 16'h0777) $display("FAIL udf_out: got %h want 0777", out); else n_pass++;
      n_total++; if ({underflow, conflict} !== 2'b10) $display("FAIL udf_flag: udf=%b cnf=%b want 1 0", underflow, conflict); else n_pass++;
      drive(0, 16'h0999, 1, 1, 1, 1);
      n_total++; if (out !== 16'h0777) $display("FAIL cnf_out: got %h want 0777", out); else n_pass++;
      n_total++; if ({underflow, conflict, stack_depth} !== 5'b11_000) $display("FAIL cnf_flag: udf=%b cnf=%b depth=%0d want 1 1 0", underflow, conflict, stack_depth); else n_pass++;
      drive(0, 16'h0000, 0, 1, 0, 0);
      drive(0, 16'h0100, 0, 0, 1, 0);
      n_total++; if ({underflow, conflict, out} !== {2'b11, 16'h0100}) $display("FAIL flags_sticky: udf=%b cnf=%b out=%h want 1 1 0100", underflow, conflict, out); else n_pass++;
      drive(0, 16'h0000, 0, 0, 0, 1);
      n_total++; if (out !== 16'h0779) $display("FAIL b2b_ret: got %h want 0779", out); else n_pass++;
      drive(1, 16'h0000, 0, 0, 0, 0);
      n_total++; if ({underflow, conflict, overflow} !== 3'b000) $display("FAIL flags_reset: got %b want 000", {underflow, conflict, overflow}); else n_pass++;
   endtask
`else
   task automatic test_macro_off();
      drive(1, 16'h0, 0, 0, 0, 0);
      drive(0, 16'h0300, 0, 0, 1, 0);
      n_total++; if (out !== 16'h0300) $display("FAIL off_call: got %h want 0300", out); else n_pass++;
      n_total++; if (stack_depth !== 3'd0) $display("FAIL off_depth: got %0d want 0", stack_depth); else n_pass++;
      drive(0, 16'h0000, 0, 1, 0, 1);
      n_total++; if (out !== 16'h0301) $display("FAIL off_ret_inc: got %h want 0301", out); else n_pass++;
      drive(0, 16'h0000, 0, 0, 1, 1);
      n_total++; if (out !== 16'h0000) $display("FAIL off_call_ret: got %h want 0000", out); else n_pass++;
      n_total++; if (dut_status() !== 8'b000_1_0_000) $display("FAIL off_tieoff: got %b want 00010000", dut_status()); else n_pass++;
   endtask
`endif

   // Random mix; expected PC values go through the scoreboard queue.
   task automatic test_random();
      logic [WIDTH-1:0] e;
      drive(1, 16'h0, 0, 0, 0, 0);
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 49) == 0), 16'($urandom_range(0, 16'hFFFF)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         exp_q.push_back(m_pc);
         e = exp_q.pop_front();
         n_total++; if (out !== e) $display("FAIL rand_out%0d: got %h want %h", k, out, e); else n_pass++;
         n_total++; if (dut_status() !== m_status()) $display("FAIL rand_status%0d: got %b want %b", k, dut_status(), m_status()); else n_pass++;
      end
   endtask

   initial begin
      reset = 1; in = '0; load = 0; inc = 0; call = 0; ret = 0;
      m_pc = '0; m_ovf = 0; m_udf = 0; m_cnf = 0;
      test_reset();
      test_inc_wrap();
      test_priority();
`ifdef PC_RETURN_STACK_EN
      test_nested_call();
      test_overflow();
      test_underflow_conflict();
`else
      test_macro_off();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
